// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: parametrised APB4 scratch-memory slave with byte strobes,
// alignment/range error response, programmable wait states and
// zero-bubble back-to-back transfers.
//
// Ports:
//   pclk_i     clock, rising edge
//   preset_i   synchronous active-high reset (clears outputs and memory)
//   paddr_i    byte address
//   psel_i     slave select
//   penable_i  access phase
//   pwrite_i   1 = write, 0 = read
//   pwdata_i   write data
//   pstrb_i    write byte strobes
//   prdata_o   read data, valid while pready_o = 1
//   pready_o   transfer complete
//   pslverr_o  error response, valid while pready_o = 1
//
// Optional build macro: APB_MEM_PSTRB_EN
//   defined   -> pstrb_i selects which byte lanes a write updates
//   undefined -> pstrb_i is ignored, writes update the full word

module apb_mem_slave_p #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [MEM_AW-1:0]       idx_q, idx_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [STRB_W-1:0]       wmask;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Setup-phase decode of the incoming address.
    logic [ADDR_WIDTH-1:0]   word_a;
    logic [MEM_AW-1:0]       setup_idx;
    logic                    setup_err;

    assign word_a    = paddr_i >> LSB;
    assign setup_idx = paddr_i[LSB +: MEM_AW];
    assign setup_err = (|(paddr_i & ALIGN_MASK)) ||
                       ({1'b0, word_a} >= DEPTH_A);

`ifdef APB_MEM_PSTRB_EN
    logic [STRB_W-1:0] strb_q, strb_d;
    assign wmask = strb_q;
`else
    logic unused_pstrb;
    assign unused_pstrb = ^pstrb_i;
    assign wmask        = '1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
`ifdef APB_MEM_PSTRB_EN
        strb_d    = strb_q;
`endif
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // penable without a preceding setup phase is ignored.
                if (psel_i && !penable_i) begin
                    state_d = ACCESS;
                    idx_d   = setup_idx;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    err_d   = setup_err;
`ifdef APB_MEM_PSTRB_EN
                    strb_d  = pstrb_i;
`endif
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (setup_err || pwrite_i) ?
                                    '0 : mem_q[setup_idx];
                    end else begin
                        cnt_d = WS;
                    end
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    // Master dropped select mid-transfer: abort.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable_i) begin
                    if (pready_q) begin
                        mem_we    = write_q && !err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q;
                            prdata_d  = (err_q || write_q) ?
                                        '0 : mem_q[idx_q];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_MEM_PSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
`ifdef APB_MEM_PSTRB_EN
            strb_q    <= strb_d;
`endif
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wmask[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb_apb_mem_slave_p: directed bench for apb_mem_slave_p.
// u0 has no wait states and a 10-bit address; u3 has three wait states.

module tb_apb_mem_slave_p;

    logic        pclk = 1'b0;
    logic        preset;
    logic [9:0]  paddr;
    logic        psel0, psel3;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_mem_slave_p #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)
    ) u0 (
        .pclk_i(pclk), .preset_i(preset), .paddr_i(paddr),
        .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
        .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata0),
        .pready_o(pready0), .pslverr_o(pslverr0)
    );

    apb_mem_slave_p #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)
    ) u3 (
        .pclk_i(pclk), .preset_i(preset), .paddr_i(paddr),
        .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
        .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata3),
        .pready_o(pready3), .pslverr_o(pslverr3)
    );

    // One APB transfer; returns data/error seen with pready and the
    // access-cycle number (0-based) where pready was high.
    task automatic xfer(input bit use3, input logic [9:0] a,
                        input bit w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic er, output int waits);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        penable = 1'b0;
        psel0   = !use3;
        psel3   = use3;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        while (!(use3 ? pready3 : pready0) && waits < 20) begin
            @(posedge pclk); #1;
            waits++;
        end
        rd = use3 ? prdata3 : prdata0;
        er = use3 ? pslverr3 : pslverr0;
        @(posedge pclk); #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if (pready0 !== 1'b0 || pready3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_pready got %b/%b want 0/0",
                     pready0, pready3);
        end
        checks++;
        if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_pslverr got %b/%b want 0/0",
                     pslverr0, pslverr3);
        end
        checks++;
        if (prdata0 !== 32'h0 || prdata3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_prdata got %h/%h want 0/0",
                     prdata0, prdata3);
        end
        preset = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        logic        er;
        int          w;
        paddr   = 10'h008;
        pwrite  = 1'b1;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        psel0   = 1'b1;
        penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        checks++;
        if (pready0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_ready got %b want 1", pready0);
        end
        preset = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outs got %b %b %h want 0 0 0",
                     pready0, pslverr0, prdata0);
        end
        preset  = 1'b0;
        psel0   = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 10'h008, 0, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_read got %h err=%b want 00000000 err=0",
                     rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          w1, w2, c0;
        c0 = cyc;
        xfer(0, 10'h004, 1, 32'hDEAD_BEEF, 4'hF, rd, er, w1);
        xfer(0, 10'h004, 0, 32'h0, 4'hF, rd, er, w2);
        checks++;
        if (w1 != 0 || w2 != 0) begin
            errors++;
            $display("FAIL b2b_latency got %0d/%0d want 0/0", w1, w2);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read got %h err=%b want deadbeef err=0",
                     rd, er);
        end
        checks++;
        if (cyc - c0 != 4) begin
            errors++;
            $display("FAIL b2b_cycles got %0d want 4", cyc - c0);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(1, 10'h000, 0, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (w != 3) begin
            errors++;
            $display("FAIL ws_latency got %0d want 3", w);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws_read0 got %h err=%b want 0 err=0", rd, er);
        end
        xfer(1, 10'h020, 1, 32'hCAFE_F00D, 4'hF, rd, er, w);
        xfer(1, 10'h020, 0, 32'h0, 4'hF, rd, er, w);
        checks++;
        if (rd !== 32'hCAFE_F00D || w != 3) begin
            errors++;
            $display("FAIL ws_rw got %h w=%0d want cafef00d w=3", rd, w);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, exp1, exp2;
        logic        er;
        int          w;
`ifdef APB_MEM_PSTRB_EN
        exp1 = 32'hFFFF_FFAA;
        exp2 = 32'hFFFF_FFAA;
`else
        exp1 = 32'h0000_00AA;
        exp2 = 32'h1234_5678;
`endif
        xfer(0, 10'h010, 1, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        xfer(0, 10'h010, 1, 32'h0000_00AA, 4'b0001, rd, er, w);
        xfer(0, 10'h010, 0, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (rd !== exp1) begin
            errors++;
            $display("FAIL strb_lane0 got %h want %h", rd, exp1);
        end
        xfer(0, 10'h010, 1, 32'h1234_5678, 4'b0000, rd, er, w);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL strb_zero_err got %b want 0", er);
        end
        xfer(0, 10'h010, 0, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (rd !== exp2) begin
            errors++;
            $display("FAIL strb_zero_read got %h want %h", rd, exp2);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(0, 10'h000, 1, 32'h1122_3344, 4'hF, rd, er, w);
        xfer(0, 10'h100, 1, 32'h0000_0055, 4'hF, rd, er, w);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_oor_write got %b want 1", er);
        end
        xfer(0, 10'h100, 0, 32'h0, 4'hF, rd, er, w);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_oor_read got %h err=%b want 0 err=1", rd, er);
        end
        xfer(0, 10'h002, 1, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_unal_write got %b want 1", er);
        end
        xfer(0, 10'h001, 0, 32'h0, 4'hF, rd, er, w);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_unal_read got %h err=%b want 0 err=1", rd, er);
        end
        xfer(0, 10'h000, 0, 32'h0, 4'hF, rd, er, w);
        checks++;
        if (rd !== 32'h1122_3344 || er !== 1'b0) begin
            errors++;
            $display("FAIL err_mem0 got %h err=%b want 11223344 err=0",
                     rd, er);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        er;
        int          w;
        // penable without setup in IDLE must not start a transfer.
        paddr   = 10'h00C;
        pwrite  = 1'b0;
        psel0   = 1'b1;
        penable = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (pready0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_penable got %b want 0", pready0);
        end
        psel0   = 1'b0;
        penable = 1'b0;
        xfer(1, 10'h00C, 1, 32'hA5A5_A5A5, 4'hF, rd, er, w);
        paddr   = 10'h00C;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        psel3   = 1'b1;
        penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (pready3 !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre_ready got %b want 0", pready3);
        end
        psel3   = 1'b0;
        penable = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            checks++;
            if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== 32'h0)
            begin
                errors++;
                $display("FAIL abort_outs got %b %b %h want 0 0 0",
                         pready3, pslverr3, prdata3);
            end
        end
        xfer(1, 10'h00C, 0, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (rd !== 32'hA5A5_A5A5 || w != 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_read got %h w=%0d err=%b want a5a5a5a5 3 0",
                     rd, w, er);
        end
    endtask

    initial begin
        preset  = 1'b1;
        paddr   = '0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        @(posedge pclk); #1;
        test_reset();
        test_reset_mid_write();
        test_back_to_back();
        test_wait_states();
        test_strobe();
        test_errors();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
